// File: rtl/shift_add_multiplier8_pkg.sv
// Shared constants and state encoding for the 8x8 shift-add multiplier.
package shift_add_multiplier8_pkg;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned ITERATIONS = 8;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_multiplier8_adder8.sv
// 8-bit ripple-style adder with carry in/out used by the multiplier datapath.
module Adder8
    import shift_add_multiplier8_pkg::*;
(
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    always_comb begin
        {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
    end

endmodule

// File: rtl/shift_add_multiplier8.sv
// Sequential 8x8 unsigned multiplier: one conditional add and right shift per cycle.
module shift_add_multiplier8
    import shift_add_multiplier8_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [WIDTH-1:0]       r_a;
    logic [2*WIDTH-1:0]     r_p;
    logic [CNT_W-1:0]       r_cnt;
    logic [2*WIDTH-1:0]     r_product;

    logic                   w_accept;
    logic                   w_last;
    logic [WIDTH-1:0]       w_addend;
    logic [WIDTH-1:0]       w_sum;
    logic                   w_cout;
    logic [2*WIDTH:0]       w_p_sum;

    assign w_accept = start && (r_state != RUN);
    assign w_last   = (r_state == RUN) && (r_cnt == CNT_W'(ITERATIONS - 1));
    assign w_addend = r_p[0] ? r_a : '0;

    Adder8 u_adder8 (
        .i_a    (r_p[2*WIDTH-1:WIDTH]),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Carry lands in P[16] before the shift, so the stored P[16] is always zero
    // and only the shifted 16 bits are kept.
    assign w_p_sum = {w_cout, w_sum, r_p[WIDTH-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (w_last) w_next_state = DONE;
            DONE:    w_next_state = start ? RUN : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_p       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (r_state == RUN) begin
            r_p   <= w_p_sum[2*WIDTH:1];
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_product <= w_p_sum[2*WIDTH:1];
        end else if (w_accept) begin
            r_a   <= multiplicand;
            r_p   <= {{WIDTH{1'b0}}, multiplier};
            r_cnt <= '0;
        end
    end

    assign busy    = (r_state == RUN);
    assign done    = (r_state == DONE);
    assign product = r_product;

endmodule

// File: tb/tb_shift_add_multiplier8.sv
// Directed-vector and randomized bench for shift_add_multiplier8.
module tb_shift_add_multiplier8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int unsigned n_cmp;
    int unsigned n_err;
    logic [15:0] last_prod;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    shift_add_multiplier8 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Starts one multiply, then walks through the 8 RUN cycles, the DONE cycle
    // and the following IDLE cycle. inject_k >= 0 raises start with FF*FF in that
    // RUN cycle; noise scrambles start/operands through the whole RUN phase.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                          input bit noise, input int inject_k, input string tag);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            chk({tag, ".busy"}, {15'b0, busy}, 16'(k < 8));
            chk({tag, ".done"}, {15'b0, done}, 16'(k == 8));
            chk({tag, ".product"}, product, (k >= 8) ? exp : last_prod);
            if (k < 8) begin
                if (noise) begin
                    start        = 1'($urandom_range(0, 1));
                    multiplicand = 8'($urandom);
                    multiplier   = 8'($urandom);
                end else if (k == inject_k) begin
                    start        = 1'b1;
                    multiplicand = 8'hFF;
                    multiplier   = 8'hFF;
                end else begin
                    start = 1'b0;
                end
            end else begin
                start = 1'b0;
            end
        end
        last_prod = exp;
    endtask

    vec_t        vecs[11];
    logic [7:0]  bb_a[45];
    logic [7:0]  bb_b[45];
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] bb_exp;

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        last_prod = 16'h0000;

        vecs[0]  = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[1]  = '{8'h0D, 8'h0B, 16'h008F};
        vecs[2]  = '{8'h00, 8'hFF, 16'h0000};
        vecs[3]  = '{8'hFF, 8'h00, 16'h0000};
        vecs[4]  = '{8'h01, 8'h01, 16'h0001};
        vecs[5]  = '{8'h80, 8'h80, 16'h4000};
        vecs[6]  = '{8'h12, 8'h34, 16'h03A8};
        vecs[7]  = '{8'hFF, 8'h01, 16'h00FF};
        vecs[8]  = '{8'h10, 8'h10, 16'h0100};
        vecs[9]  = '{8'hAA, 8'h55, 16'h3872};
        vecs[10] = '{8'h01, 8'hFF, 16'h00FF};

        // Reset with start held high: nothing may be accepted.
        rst_n        = 1'b0;
        start        = 1'b1;
        multiplicand = 8'hFF;
        multiplier   = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", {15'b0, busy}, 16'h0000);
        chk("rst.done", {15'b0, done}, 16'h0000);
        chk("rst.product", product, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // First vector starts on the very first edge after release.
        for (int i = 0; i < 11; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, -1, $sformatf("vec%0d", i));

        // Late start request in cycle 4 of RUN is ignored and not executed later.
        run_op(8'h03, 8'h05, 16'h000F, 1'b0, 3, "ignore_start");
        repeat (3) begin
            @(posedge clk); #1;
            chk("ignore_start.idle_busy", {15'b0, busy}, 16'h0000);
            chk("ignore_start.idle_done", {15'b0, done}, 16'h0000);
            chk("ignore_start.hold", product, 16'h000F);
        end

        // Reset in cycle 5 of RUN aborts the operation.
        multiplicand = 8'hFF;
        multiplier   = 8'h02;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort.busy_before", {15'b0, busy}, 16'h0001);
        rst_n = 1'b0;
        #1;
        chk("abort.busy", {15'b0, busy}, 16'h0000);
        chk("abort.done", {15'b0, done}, 16'h0000);
        chk("abort.product", product, 16'h0000);
        start = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("abort.hold_busy", {15'b0, busy}, 16'h0000);
            chk("abort.hold_done", {15'b0, done}, 16'h0000);
        end
        @(negedge clk);
        start     = 1'b0;
        rst_n     = 1'b1;
        last_prod = 16'h0000;
        run_op(8'h02, 8'h03, 16'h0006, 1'b0, -1, "post_abort");

        // start held high: a new acceptance every 9 edges, operands change every cycle.
        for (int j = 0; j < 45; j++) begin
            bb_a[j]      = 8'($urandom);
            bb_b[j]      = 8'($urandom);
            multiplicand = bb_a[j];
            multiplier   = bb_b[j];
            start        = 1'b1;
            @(posedge clk); #1;
            chk("b2b.done", {15'b0, done}, 16'((j % 9) == 8));
            chk("b2b.busy", {15'b0, busy}, 16'((j % 9) != 8));
            if ((j % 9) == 8) begin
                bb_exp = 16'(bb_a[j-8]) * 16'(bb_b[j-8]);
                chk("b2b.product", product, bb_exp);
                last_prod = bb_exp;
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("b2b.end_done", {15'b0, done}, 16'h0000);
        chk("b2b.end_busy", {15'b0, busy}, 16'h0000);

        // Random operands, random idle gaps, random noise during RUN.
        for (int n = 0; n < 1000; n++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                start        = 1'b0;
                multiplicand = 8'($urandom);
                multiplier   = 8'($urandom);
                @(posedge clk); #1;
                chk("rnd.idle_hold", product, last_prod);
                chk("rnd.idle_busy", {15'b0, busy}, 16'h0000);
            end
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ra, rb, 16'(ra) * 16'(rb), 1'b1, -1, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
